// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared state type, button indices and pin-encoding helper for the pad serializer
package nes_pad_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, EXHAUST} pad_state_t;

    localparam int BTN_A     = 0;
    localparam int BTN_B     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_R     = 11;

    function automatic logic to_pin(input logic logical, input logic active_lo);
        return logical ^ active_lo;
    endfunction

endpackage

// File: rtl/nes_pad_serializer_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an async input plus one flop for rise/fall detection
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_async,
    output logic [1:0] o_edge
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    assign w_level = r_sync[STAGES-1];
    assign o_edge  = {r_prev & ~w_level, ~r_prev & w_level};

    // shift the async input through the chain and remember the previous synced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= w_level;
        end
    end

endmodule

// File: rtl/nes_pad_serializer.sv
// nes_pad_serializer: controller-port emulator shifting NUM_PADS button sets out to a console reader
module nes_pad_serializer
    import nes_pad_pkg::*;
#(
    parameter int NUM_PADS       = 2,
    parameter int BITS           = 8,
    parameter int SYNC_STAGES    = 2,
    parameter bit DATA_ACTIVE_LO = 1'b1,
    parameter bit FILL_LOGIC     = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PADS*BITS-1:0]   btn_in,
    input  logic                       pad_latch,
    input  logic                       pad_clk,
    output logic [NUM_PADS-1:0]        data_out,
    output logic [$clog2(BITS+1)-1:0]  bit_idx,
    output logic                       frame_done,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int            IW   = $clog2(BITS+1);
    localparam logic [IW-1:0] LAST = IW'(BITS-1);

    pad_state_t                 r_state, w_next;
    logic [IW-1:0]              r_idx;
    logic                       r_frame_done, r_overrun;
    logic [NUM_PADS*BITS-1:0]   r_btn_pipe [SYNC_STAGES];
    logic [1:0]                 w_latch_edge, w_clk_edge;
    logic                       w_latch_rise, w_latch_fall, w_clk_rise, w_shift, w_last;
    logic [NUM_PADS*BITS-1:0]   w_btn_d;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk(clk), .rst_n(reset), .i_async(pad_latch), .o_edge(w_latch_edge)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk(clk), .rst_n(reset), .i_async(pad_clk), .o_edge(w_clk_edge)
    );

    assign w_latch_rise = w_latch_edge == 2'b01;
    assign w_latch_fall = w_latch_edge == 2'b10;
    assign w_clk_rise   = w_clk_edge == 2'b01;
    assign w_shift      = r_state == SHIFT && w_clk_rise && !w_latch_rise;
    assign w_last       = w_shift && r_idx == LAST;
    assign w_btn_d      = r_btn_pipe[SYNC_STAGES-1];
    assign bit_idx      = r_idx;
    assign frame_done   = r_frame_done;
    assign overrun      = r_overrun;

    // next state: latch edges steer the frame, a clk rise on the last bit exhausts it
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, EXHAUST: w_next = w_latch_rise ? LOAD : r_state;
            LOAD:          w_next = w_latch_fall ? SHIFT : LOAD;
            SHIFT:         w_next = w_latch_rise ? LOAD : w_last ? EXHAUST : SHIFT;
            default:       w_next = IDLE;
        endcase
    end

    // delay buttons to match the latch synchroniser so LOAD output lags btn_in like a pad edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_btn_pipe[i] <= '0;
        end else begin
            r_btn_pipe[0] <= btn_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_btn_pipe[i] <= r_btn_pipe[i-1];
        end
    end

    // state, saturating bit counter, frame pulse and sticky overrun (set beats clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_idx        <= (w_next == LOAD) ? '0 : w_shift ? r_idx + 1'b1 : r_idx;
            r_frame_done <= w_last;
            r_overrun    <= (r_state == SHIFT && w_latch_rise && r_idx != '0) ? 1'b1 :
                            overrun_clr ? 1'b0 : r_overrun;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [BITS-1:0] r_shreg;
        logic            w_logic;

        assign w_logic     = (r_state == IDLE) ? 1'b0 : (r_state == EXHAUST) ? FILL_LOGIC : r_shreg[0];
        assign data_out[p] = to_pin(w_logic, DATA_ACTIVE_LO);

        // parallel load while latched, shift in FILL_LOGIC from the top on each accepted clk rise
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)               r_shreg <= '0;
            else if (w_next == LOAD) r_shreg <= w_btn_d[p*BITS +: BITS];
            else if (w_shift)        r_shreg <= {FILL_LOGIC, r_shreg[BITS-1:1]};
        end
    end

endmodule
